// File: rtl/mmu_access_unit_pkg.sv
// Shared types for the memory access unit: access kinds, exception mask, bank map, FSM states.
package mmu_access_unit_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned BANK_W = 4;

    localparam logic [BANK_W-1:0] MMU_BANK_INST = 4'h0;
    localparam logic [BANK_W-1:0] MMU_BANK_DATA = 4'h1;

    typedef enum logic [2:0] {
        MEM_ACCESS_BYTE   = 3'd0,
        MEM_ACCESS_BYTE_U = 3'd1,
        MEM_ACCESS_HALF   = 3'd2,
        MEM_ACCESS_HALF_U = 3'd3,
        MEM_ACCESS_WORD   = 3'd4
    } mem_access_t;

    typedef struct packed {
        logic illegal_write;
        logic misaligned;
        logic access_fault;
    } mem_exception_mask_t;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_READ_WAIT = 2'd1,
        S_RMW_WAIT  = 2'd2
    } mmu_state_t;

    // Natural alignment check for the access size at the given byte lane.
    function automatic logic is_misaligned(mem_access_t access, logic [1:0] lane);
        case (access)
            MEM_ACCESS_HALF, MEM_ACCESS_HALF_U: return lane[0];
            MEM_ACCESS_WORD:                    return |lane;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mmu_access_unit_lane_align.sv
// Byte-lane alignment: load extraction/extension and sub-word store merge into a read word.
module mmu_lane_align
    import mmu_access_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  mem_access_t access,
    input  logic [31:0] wr_data,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'(word >> {lane, 3'b000});
        half_sel = lane[1] ? word[31:16] : word[15:0];

        load_data = word;
        case (access)
            MEM_ACCESS_BYTE:   load_data = {{24{byte_sel[7]}}, byte_sel};
            MEM_ACCESS_BYTE_U: load_data = {24'h0, byte_sel};
            MEM_ACCESS_HALF:   load_data = {{16{half_sel[15]}}, half_sel};
            MEM_ACCESS_HALF_U: load_data = {16'h0, half_sel};
            default:           load_data = word;
        endcase

        // Unsigned kinds store exactly like their signed counterparts.
        store_data = word;
        case (access)
            MEM_ACCESS_BYTE, MEM_ACCESS_BYTE_U:
                store_data[{lane, 3'b000} +: 8] = wr_data[7:0];
            MEM_ACCESS_HALF, MEM_ACCESS_HALF_U: begin
                if (lane[1]) store_data[31:16] = wr_data[15:0];
                else         store_data[15:0]  = wr_data[15:0];
            end
            default:
                store_data = wr_data;
        endcase
    end

endmodule

// File: rtl/mmu_access_unit.sv
// Memory access unit: decodes/validates core requests and serves them from the banked SRAM.
module mmu_access_unit
    import mmu_access_unit_pkg::*;
#(
    parameter int unsigned ADDR_W        = 12,
    parameter bit          INST_WRITABLE = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [31:0]         req_addr,
    input  logic                req_wr_ena,
    input  logic [31:0]         req_wr_data,
    input  mem_access_t         req_access,
    output logic                rsp_valid,
    output logic [31:0]         rsp_rd_data,
    output mem_exception_mask_t rsp_exception,
    output logic                sram_cs,
    output logic                sram_bank,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic                sram_wr_ena,
    output logic [31:0]         sram_wr_data,
    input  logic [31:0]         sram_rd_data
);

    localparam int unsigned LOW_BITS   = ADDR_W + 2;
    localparam logic [27:0] RANGE_MASK = ~28'((64'd1 << LOW_BITS) - 64'd1);

    mmu_state_t          state_q, state_d;
    logic [1:0]          lane_q;
    logic [ADDR_W-1:0]   word_addr_q;
    logic                bank_q;
    mem_access_t         access_q;
    logic [31:0]         wr_data_q;

    logic                capture_c;
    logic                rsp_valid_d;
    logic [31:0]         rsp_rd_data_d;
    mem_exception_mask_t rsp_exception_d;

    logic [3:0]          req_bank_c;
    mem_exception_mask_t exc_c;
    logic                fault_c;
    logic                cs_c, wr_ena_c;
    logic [31:0]         load_data_c, merge_data_c;

    // Request decode and fault detection; all fault bits are reported together.
    always_comb begin
        req_bank_c          = req_addr[31:28];
        exc_c.access_fault  = ((req_bank_c != MMU_BANK_INST) && (req_bank_c != MMU_BANK_DATA))
                              || (|(req_addr[27:0] & RANGE_MASK));
        exc_c.misaligned    = is_misaligned(req_access, req_addr[1:0]);
        exc_c.illegal_write = req_wr_ena && (req_bank_c == MMU_BANK_INST) && !INST_WRITABLE;
        fault_c             = exc_c.access_fault | exc_c.misaligned | exc_c.illegal_write;
    end

    mmu_lane_align u_lane_align (
        .word       (sram_rd_data),
        .lane       (lane_q),
        .access     (access_q),
        .wr_data    (wr_data_q),
        .load_data  (load_data_c),
        .store_data (merge_data_c)
    );

    assign req_ready = (state_q == S_IDLE);

    // Next-state, SRAM strobes and response next-values.
    always_comb begin
        state_d         = state_q;
        capture_c       = 1'b0;
        cs_c            = 1'b0;
        wr_ena_c        = 1'b0;
        sram_bank       = bank_q;
        sram_addr       = word_addr_q;
        sram_wr_data    = merge_data_c;
        rsp_valid_d     = 1'b0;
        rsp_rd_data_d   = rsp_rd_data;
        rsp_exception_d = rsp_exception;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    capture_c = 1'b1;
                    sram_bank = (req_bank_c == MMU_BANK_DATA);
                    sram_addr = req_addr[LOW_BITS-1:2];
                    if (fault_c) begin
                        rsp_valid_d     = 1'b1;
                        rsp_rd_data_d   = 32'h0;
                        rsp_exception_d = exc_c;
                    end else if (!req_wr_ena) begin
                        cs_c    = 1'b1;
                        state_d = S_READ_WAIT;
                    end else if (req_access == MEM_ACCESS_WORD) begin
                        cs_c            = 1'b1;
                        wr_ena_c        = 1'b1;
                        sram_wr_data    = req_wr_data;
                        rsp_valid_d     = 1'b1;
                        rsp_rd_data_d   = 32'h0;
                        rsp_exception_d = '0;
                    end else begin
                        cs_c    = 1'b1;
                        state_d = S_RMW_WAIT;
                    end
                end
            end
            S_READ_WAIT: begin
                rsp_valid_d     = 1'b1;
                rsp_rd_data_d   = load_data_c;
                rsp_exception_d = '0;
                state_d         = S_IDLE;
            end
            S_RMW_WAIT: begin
                cs_c            = 1'b1;
                wr_ena_c        = 1'b1;
                rsp_valid_d     = 1'b1;
                rsp_rd_data_d   = 32'h0;
                rsp_exception_d = '0;
                state_d         = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Reset kills the strobes immediately, aborting any pending merge write.
    assign sram_cs     = cs_c & rst;
    assign sram_wr_ena = wr_ena_c & rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane_q        <= 2'b00;
            word_addr_q   <= '0;
            bank_q        <= 1'b0;
            access_q      <= MEM_ACCESS_BYTE;
            wr_data_q     <= 32'h0;
            rsp_valid     <= 1'b0;
            rsp_rd_data   <= 32'h0;
            rsp_exception <= '0;
        end else begin
            if (capture_c) begin
                lane_q      <= req_addr[1:0];
                word_addr_q <= req_addr[LOW_BITS-1:2];
                bank_q      <= (req_bank_c == MMU_BANK_DATA);
                access_q    <= req_access;
                wr_data_q   <= req_wr_data;
            end
            rsp_valid     <= rsp_valid_d;
            rsp_rd_data   <= rsp_rd_data_d;
            rsp_exception <= rsp_exception_d;
        end
    end

endmodule

// File: tb/tb_mmu_access_unit.sv
// Scoreboard bench for mmu_access_unit with a behavioural two-bank SRAM.
module tb_mmu_access_unit;
    import mmu_access_unit_pkg::*;

    localparam int unsigned ADDR_W = 12;
    localparam logic [2:0] E_ACC = 3'b001;
    localparam logic [2:0] E_MIS = 3'b010;
    localparam logic [2:0] E_ILL = 3'b100;

    logic                clk = 1'b0;
    logic                rst;
    logic                req_valid;
    logic                req_ready;
    logic [31:0]         req_addr;
    logic                req_wr_ena;
    logic [31:0]         req_wr_data;
    mem_access_t         req_access;
    logic                rsp_valid;
    logic [31:0]         rsp_rd_data;
    mem_exception_mask_t rsp_exception;
    logic                sram_cs;
    logic                sram_bank;
    logic [ADDR_W-1:0]   sram_addr;
    logic                sram_wr_ena;
    logic [31:0]         sram_wr_data;
    logic [31:0]         sram_rd_data;

    mmu_access_unit #(.ADDR_W(ADDR_W), .INST_WRITABLE(1'b0)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wr_ena(req_wr_ena), .req_wr_data(req_wr_data), .req_access(req_access),
        .rsp_valid(rsp_valid), .rsp_rd_data(rsp_rd_data), .rsp_exception(rsp_exception),
        .sram_cs(sram_cs), .sram_bank(sram_bank), .sram_addr(sram_addr),
        .sram_wr_ena(sram_wr_ena), .sram_wr_data(sram_wr_data), .sram_rd_data(sram_rd_data)
    );

    always #5 clk = ~clk;

    // SRAM model with a side preload port for the bench.
    logic [31:0] mem [0:1][0:(1<<ADDR_W)-1];
    logic        pl_en = 1'b0;
    logic        pl_bank;
    logic [ADDR_W-1:0] pl_addr;
    logic [31:0] pl_data;

    always @(posedge clk) begin
        if (pl_en) mem[pl_bank][pl_addr] <= pl_data;
        else if (sram_cs) begin
            if (sram_wr_ena) mem[sram_bank][sram_addr] <= sram_wr_data;
            else             sram_rd_data <= mem[sram_bank][sram_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rd;
        logic [2:0]  exc;
        int          due;
    } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin
        if (rsp_valid) begin
            if (sb.size() == 0) check("unexpected_rsp", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_rd_data", rsp_rd_data, e.rd);
                check("rsp_exception", {29'b0, rsp_exception}, {29'b0, e.exc});
                check("rsp_latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    task automatic preload(input logic bank, input int idx, input logic [31:0] data);
        pl_bank = bank;
        pl_addr = ADDR_W'(idx);
        pl_data = data;
        pl_en   = 1'b1;
        @(posedge clk); #1;
        pl_en   = 1'b0;
    endtask

    // Drive one request; after return the time is just past its accept edge.
    task automatic send(input logic [31:0] addr, input logic wr, input logic [31:0] data,
                        input mem_access_t acc, input logic [31:0] exp_rd,
                        input logic [2:0] exp_exc, input bit hold, input bit track);
        bit   done;
        bit   fault;
        exp_t e;
        fault       = (exp_exc != 3'b000);
        req_addr    = addr;
        req_wr_ena  = wr;
        req_wr_data = data;
        req_access  = acc;
        req_valid   = 1'b1;
        done        = 1'b0;
        for (int w = 0; w < 20 && !done; w++) begin
            #1;
            if (req_ready) begin
                check("accept_cs", {31'b0, sram_cs}, {31'b0, !fault});
                check("accept_wr", {31'b0, sram_wr_ena}, {31'b0, !fault && wr && acc == MEM_ACCESS_WORD});
                @(posedge clk); #1;
                done = 1'b1;
            end else begin
                @(posedge clk);
            end
        end
        if (!done) check("accept_timeout", 32'd0, 32'd1);
        else if (track) begin
            e.rd  = exp_rd;
            e.exc = exp_exc;
            e.due = cyc + ((fault || (wr && acc == MEM_ACCESS_WORD)) ? 0 : 1);
            sb.push_back(e);
        end
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
    endtask

    logic [31:0] bb_data [4];
    int          t0;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        req_valid = 1'b0; req_addr = 32'h0; req_wr_ena = 1'b0;
        req_wr_data = 32'h0; req_access = MEM_ACCESS_WORD;
        repeat (3) @(posedge clk);
        #1;
        req_valid = 1'b1;
        #1;
        check("reset_sram_cs", {31'b0, sram_cs}, 32'd0);
        check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset_rsp_rd_data", rsp_rd_data, 32'd0);
        check("reset_rsp_exception", {29'b0, rsp_exception}, 32'd0);
        check("reset_req_ready", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // Loads with extension.
        preload(1'b1, 4, 32'hDEADBEEF);
        send(32'h1000_0010, 1'b0, 32'h0, MEM_ACCESS_WORD, 32'hDEADBEEF, 3'b000, 1'b0, 1'b1);
        drain();
        preload(1'b1, 4, 32'h80112233);
        send(32'h1000_0013, 1'b0, 32'h0, MEM_ACCESS_BYTE,   32'hFFFFFF80, 3'b000, 1'b0, 1'b1);
        send(32'h1000_0013, 1'b0, 32'h0, MEM_ACCESS_BYTE_U, 32'h00000080, 3'b000, 1'b0, 1'b1);
        send(32'h1000_0011, 1'b0, 32'h0, MEM_ACCESS_BYTE,   32'h00000022, 3'b000, 1'b0, 1'b1);
        drain();

        // Sub-word stores via read-modify-write.
        preload(1'b1, 4, 32'h11223344);
        send(32'h1000_0012, 1'b1, 32'h0000ABCD, MEM_ACCESS_HALF, 32'h0, 3'b000, 1'b0, 1'b1);
        drain();
        check("mem_half_store", mem[1][4], 32'hABCD3344);
        send(32'h1000_0012, 1'b0, 32'h0, MEM_ACCESS_HALF,   32'hFFFFABCD, 3'b000, 1'b0, 1'b1);
        send(32'h1000_0010, 1'b0, 32'h0, MEM_ACCESS_HALF_U, 32'h00003344, 3'b000, 1'b0, 1'b1);
        send(32'h1000_0011, 1'b1, 32'hFFFFFF5A, MEM_ACCESS_BYTE_U, 32'h0, 3'b000, 1'b0, 1'b1);
        drain();
        check("mem_byte_store", mem[1][4], 32'hABCD5A44);

        // Faults respond next cycle with no SRAM access.
        send(32'h1000_0012, 1'b0, 32'h0, MEM_ACCESS_WORD, 32'h0, E_MIS, 1'b0, 1'b1);
        send(32'h0000_0020, 1'b1, 32'h12345678, MEM_ACCESS_WORD, 32'h0, E_ILL, 1'b0, 1'b1);
        send(32'hF000_0000, 1'b0, 32'h0, MEM_ACCESS_WORD, 32'h0, E_ACC, 1'b0, 1'b1);
        send(32'h0000_0001, 1'b1, 32'h0, MEM_ACCESS_HALF, 32'h0, E_ILL | E_MIS, 1'b0, 1'b1);
        send(32'h1000_4000, 1'b0, 32'h0, MEM_ACCESS_BYTE, 32'h0, E_ACC, 1'b0, 1'b1);
        drain();
        check("mem_inst_untouched", mem[0][8], 32'h0);

        // Back-to-back word stores, one per cycle.
        for (int i = 0; i < 4; i++) bb_data[i] = $urandom;
        t0 = cyc;
        for (int i = 0; i < 4; i++)
            send(32'h1000_0020 + 32'(4 * i), 1'b1, bb_data[i], MEM_ACCESS_WORD,
                 32'h0, 3'b000, (i < 3), 1'b1);
        check("b2b_cycles", 32'(cyc - t0), 32'd4);
        drain();
        for (int i = 0; i < 4; i++) check("b2b_mem", mem[1][8 + i], bb_data[i]);

        // Reset during the merge write aborts it with no response.
        preload(1'b1, 4, 32'hCAFEF00D);
        send(32'h1000_0010, 1'b1, 32'h00007777, MEM_ACCESS_HALF, 32'h0, 3'b000, 1'b0, 1'b0);
        check("rmw_pre_reset_cs", {31'b0, sram_cs}, 32'd1);
        #1 rst = 1'b0;
        #1;
        check("rmw_reset_cs", {31'b0, sram_cs}, 32'd0);
        check("rmw_reset_wr", {31'b0, sram_wr_ena}, 32'd0);
        @(posedge clk); #1;
        check("rmw_reset_rsp", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check("rmw_aborted_mem", mem[1][4], 32'hCAFEF00D);
        send(32'h1000_0010, 1'b0, 32'h0, MEM_ACCESS_WORD, 32'hCAFEF00D, 3'b000, 1'b0, 1'b1);
        drain();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
